// File: rtl/pool_line_feeder.sv
// pool_line_feeder: pairs consecutive conv rows into a line-0/line-1 vector for the 2x2 max-pool array,
// issues one max_en pulse per pair and tracks pool latency and frame position.
module pool_line_feeder #(
    parameter int ROW_W    = 28,
    parameter int DATA_W   = 16,
    parameter int ROWS     = 28,
    parameter int POOL_LAT = 1,
    localparam int LW = ROW_W * DATA_W,
    localparam int PW = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LW-1:0]       row_in,
    input  logic                row_valid,
    output logic                row_ready,
    input  logic                pool_ready,
    input  logic                flush,
    output logic [2*LW-1:0]     fm_out,
    output logic [ROW_W/2-1:0]  max_en,
    output logic                pool_valid,
    output logic [PW-1:0]       pair_idx,
    output logic                frame_done
);
    if (ROW_W % 2 != 0) begin : g_bad_row_w
        $error("ROW_W must be even");
    end
    if (ROWS % 2 != 0) begin : g_bad_rows
        $error("ROWS must be even");
    end
    if (POOL_LAT < 1) begin : g_bad_lat
        $error("POOL_LAT must be >= 1");
    end

    typedef enum logic [1:0] {WAIT_ROW0, WAIT_ROW1, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       line0_q, line1_q;
    logic [PW-1:0]       cnt_q, cnt_d, pair_idx_q;
    logic [POOL_LAT-1:0] lat_q;
    logic                xfer, issue, last;

    assign row_ready  = !rst && !flush && state_q != ISSUE;
    assign xfer       = row_valid && row_ready;
    assign issue      = !rst && !flush && state_q == ISSUE && pool_ready;
    assign last       = cnt_q == PW'(ROWS / 2 - 1);
    assign max_en     = {(ROW_W/2){issue}};
    assign frame_done = issue && last;
    assign fm_out     = {line1_q, line0_q};
    assign pool_valid = lat_q[POOL_LAT-1];
    assign pair_idx   = pair_idx_q;

    always_comb begin
        state_d = (flush || issue) ? WAIT_ROW0 :
                  (xfer && state_q == WAIT_ROW0) ? WAIT_ROW1 :
                  (xfer && state_q == WAIT_ROW1) ? ISSUE : state_q;
        cnt_d   = (flush || (issue && last)) ? '0 : issue ? cnt_q + PW'(1) : cnt_q;
    end

    // Flush leaves lat_q alone so results already issued still report valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_ROW0;
            line0_q    <= '0;
            line1_q    <= '0;
            cnt_q      <= '0;
            pair_idx_q <= '0;
            lat_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= POOL_LAT'({lat_q, issue});
            if (xfer && state_q == WAIT_ROW0) line0_q <= row_in;
            if (xfer && state_q == WAIT_ROW1) line1_q <= row_in;
            if (issue) pair_idx_q <= cnt_q;
        end
    end
endmodule

// File: tb/tb_pool_line_feeder.sv
// tb_pool_line_feeder: table vectors, corner sequences and random traffic against a row-buffer model,
// driving a POOL_LAT=1 and a POOL_LAT=3 instance with shared stimulus.
module tb_pool_line_feeder;
    localparam int RW = 28, DW = 16, NR = 28, LW = RW * DW, HW = RW / 2, NP = NR / 2;

    logic clk = 0, rst = 1, row_valid = 0, pool_ready = 0, flush = 0;
    logic [LW-1:0] row_in = '0;
    logic rr1, rr3, pv1, pv3, fd1, fd3;
    logic [2*LW-1:0] fm1, fm3;
    logic [HW-1:0] me1, me3;
    logic [3:0] pi1, pi3;

    always #5 clk = ~clk;

    pool_line_feeder #(.ROW_W(RW), .DATA_W(DW), .ROWS(NR), .POOL_LAT(1)) u1 (
        .clk(clk), .rst(rst), .row_in(row_in), .row_valid(row_valid), .row_ready(rr1),
        .pool_ready(pool_ready), .flush(flush), .fm_out(fm1), .max_en(me1),
        .pool_valid(pv1), .pair_idx(pi1), .frame_done(fd1));
    pool_line_feeder #(.ROW_W(RW), .DATA_W(DW), .ROWS(NR), .POOL_LAT(3)) u3 (
        .clk(clk), .rst(rst), .row_in(row_in), .row_valid(row_valid), .row_ready(rr3),
        .pool_ready(pool_ready), .flush(flush), .fm_out(fm3), .max_en(me3),
        .pool_valid(pv3), .pair_idx(pi3), .frame_done(fd3));

    int nvec = 0, nerr = 0;

    // Model: how many rows are buffered (0..2), their contents, pairs issued this frame.
    int held = 0, pairs = 0, pidx = 0;
    logic [LW-1:0] ml0 = '0, ml1 = '0;
    logic [3:0] hist = '0;

    task automatic chk(input string nm, input logic [2*LW-1:0] act, input logic [2*LW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk(input int b);
        logic [LW-1:0] r;
        for (int j = 0; j < RW; j++) r[j*DW +: DW] = 16'(b + j);
        return r;
    endfunction

    function automatic bit m_issue();
        return !rst && !flush && held == 2 && pool_ready;
    endfunction

    task automatic check_all();
        bit rdy, iss;
        rdy = !rst && !flush && held < 2;
        iss = m_issue();
        chk("row_ready1", rr1, rdy);
        chk("row_ready3", rr3, rdy);
        chk("max_en1", me1, iss ? {HW{1'b1}} : '0);
        chk("max_en3", me3, iss ? {HW{1'b1}} : '0);
        chk("frame_done1", fd1, iss && pairs == NP - 1);
        chk("frame_done3", fd3, iss && pairs == NP - 1);
        chk("fm_out1", fm1, {ml1, ml0});
        chk("fm_out3", fm3, {ml1, ml0});
        chk("pool_valid1", pv1, hist[0]);
        chk("pool_valid3", pv3, hist[2]);
        chk("pair_idx1", pi1, pidx);
        chk("pair_idx3", pi3, pidx);
    endtask

    task automatic update();
        bit iss, xfer;
        iss  = m_issue();
        xfer = row_valid && !rst && !flush && held < 2;
        if (rst) begin
            held = 0; pairs = 0; pidx = 0; ml0 = '0; ml1 = '0; hist = '0;
        end else begin
            hist = {hist[2:0], iss};
            if (flush) begin
                held = 0; pairs = 0;
            end else if (iss) begin
                held = 0; pidx = pairs; pairs = (pairs + 1) % NP;
            end else if (xfer) begin
                if (held == 0) ml0 = row_in; else ml1 = row_in;
                held++;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic at_pos();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic drive(input bit r, input bit v, input bit p, input bit f, input int b);
        rst = r; row_valid = v; pool_ready = p; flush = f; row_in = mk(b);
    endtask

    typedef struct {
        bit r, v, p, f;
        int b;
        bit e_rdy, e_me, e_pv, e_done;
        int e_idx, e_l0, e_l1;
    } vec_t;

    function automatic vec_t mv(bit r, bit v, bit p, bit f, int b,
                                bit er, bit em, bit epv, bit ed, int ei, int el0, int el1);
        vec_t x;
        x.r = r; x.v = v; x.p = p; x.f = f; x.b = b;
        x.e_rdy = er; x.e_me = em; x.e_pv = epv; x.e_done = ed;
        x.e_idx = ei; x.e_l0 = el0; x.e_l1 = el1;
        return x;
    endfunction

    vec_t tbl[$];
    int pulses[$], idxs[$];
    int ndone, done_at;
    bit prev_pulse;

    initial begin
        tbl.push_back(mv(1,0,1,0,0,    0,0,0,0,0,0,0));
        tbl.push_back(mv(0,1,1,0,0,    1,0,0,0,0,0,0));
        tbl.push_back(mv(0,1,1,0,100,  1,0,0,0,0,0,0));
        tbl.push_back(mv(0,1,1,0,200,  0,1,0,0,0,0,100));
        tbl.push_back(mv(0,1,0,0,200,  1,0,1,0,0,0,100));
        tbl.push_back(mv(0,1,0,0,300,  1,0,0,0,0,200,100));
        for (int i = 0; i < 5; i++) tbl.push_back(mv(0,1,0,0,400, 0,0,0,0,0,200,300));
        tbl.push_back(mv(0,0,1,0,0,    0,1,0,0,0,200,300));
        tbl.push_back(mv(0,1,1,0,500,  1,0,1,0,1,200,300));
        tbl.push_back(mv(0,1,1,1,600,  0,0,0,0,1,500,300));
        tbl.push_back(mv(0,1,1,0,700,  1,0,0,0,1,500,300));
        tbl.push_back(mv(0,1,1,0,800,  1,0,0,0,1,700,300));
        tbl.push_back(mv(0,0,1,0,0,    0,1,0,0,1,700,800));
        tbl.push_back(mv(0,1,1,0,900,  1,0,1,0,0,700,800));
        tbl.push_back(mv(0,0,1,0,0,    1,0,0,0,0,900,800));
        tbl.push_back(mv(0,0,1,0,0,    1,0,0,0,0,900,800));
        tbl.push_back(mv(0,1,1,0,1000, 1,0,0,0,0,900,800));
        tbl.push_back(mv(0,0,1,0,0,    0,1,0,0,0,900,1000));
        tbl.push_back(mv(0,0,0,0,0,    1,0,1,0,1,900,1000));

        drive(1, 0, 0, 0, 0);
        at_pos();
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].f, tbl[i].b);
            at_neg();
            chk("t_ready", rr1, tbl[i].e_rdy);
            chk("t_max_en", me1, tbl[i].e_me ? {HW{1'b1}} : '0);
            chk("t_pool_valid", pv1, tbl[i].e_pv);
            chk("t_done", fd1, tbl[i].e_done);
            chk("t_pair_idx", pi1, tbl[i].e_idx);
            chk("t_line0_px0", fm1[0 +: DW], 16'(tbl[i].e_l0));
            chk("t_line1_px0", fm1[LW +: DW], 16'(tbl[i].e_l1));
            at_pos();
        end

        // Full frame plus the first pair of the next one, rows streamed continuously.
        drive(1, 0, 0, 0, 0);
        at_neg(); at_pos();
        ndone = 0; done_at = -1; prev_pulse = 0;
        for (int c = 0; c < 46; c++) begin
            drive(0, 1, 1, 0, 2000 + c);
            at_neg();
            if (prev_pulse) idxs.push_back(int'(pi1));
            prev_pulse = me1 != 0;
            if (me1 != 0) pulses.push_back(c);
            if (fd1) begin ndone++; done_at = pulses.size(); end
            at_pos();
        end
        chk("ff_pulse_count", pulses.size(), 15);
        foreach (pulses[k]) chk("ff_pulse_cycle", pulses[k], 2 + 3 * k);
        chk("ff_done_count", ndone, 1);
        chk("ff_done_pulse", done_at, 14);
        foreach (idxs[k]) chk("ff_pair_idx", idxs[k], k % NP);

        // Reset while a pair waits in ISSUE and a result is still in flight on the LAT=3 unit.
        drive(1, 0, 0, 0, 0);
        at_neg(); at_pos();
        drive(0, 1, 1, 0, 3000); at_neg(); at_pos();
        drive(0, 1, 1, 0, 3100); at_neg(); at_pos();
        drive(0, 0, 1, 0, 0);    at_neg(); at_pos();
        drive(0, 1, 0, 0, 3200); at_neg(); at_pos();
        drive(0, 1, 0, 0, 3300); at_neg(); at_pos();
        drive(1, 0, 1, 0, 0);
        at_neg();
        chk("rst_max_en", me3, '0);
        at_pos();
        drive(0, 1, 1, 0, 3400);
        at_neg();
        chk("rst_pool_valid3", pv3, 0);
        chk("rst_fm_out", fm3, '0);
        chk("rst_pair_idx", pi3, 0);
        at_pos();
        drive(0, 1, 1, 0, 3500); at_neg(); at_pos();
        drive(0, 0, 1, 0, 0);
        at_neg();
        chk("rst_reissue", me3, {HW{1'b1}});
        at_pos();
        drive(0, 0, 0, 0, 0);
        at_neg();
        chk("rst_restart_idx", pi3, 0);
        at_pos();

        for (int c = 0; c < 800; c++) begin
            rst        = $urandom_range(0, 99) == 0;
            flush      = $urandom_range(0, 29) == 0;
            row_valid  = ($urandom % 3) != 0;
            pool_ready = ($urandom % 4) != 0;
            for (int k = 0; k < LW / 32; k++) row_in[k*32 +: 32] = $urandom();
            at_neg();
            at_pos();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
